// File: rtl/seg7_scan_driver.sv
// Scans eight hex digits onto common-anode 7-segment displays, with leading-zero blanking, guard time and rollover blink.
// Latency: anode/seg are registered from the scan counters (1 cycle); shadow->active transfer happens only at frame end.
// Backpressure: none; update/rollover strobes are accepted every cycle and scanning never stalls.
module seg7_scan_driver #(
  parameter int CLK_HZ       = 50000000,
  parameter int SCAN_HZ      = 1000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic        update,
  input  logic        lz_en,
  input  logic        rollover,
  output logic [7:0]  anode,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_GUARD  = PW'(GUARD);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES);

  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic [31:0]   r_shadow;
  logic [31:0]   r_active;
  logic [BW-1:0] r_blink;
  logic [7:0]    r_anode;
  logic [7:0]    r_seg;
  logic          r_frame_done;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic [7:0]    w_upper_zero;
  logic          w_blanked;
  logic          w_anode_on;
  logic [7:0]    w_anode_next;
  logic [6:0]    w_hex;

  assign w_slot_end  = (r_pre == PRE_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 3'd7);
  assign w_digit     = r_active[{r_idx, 2'b00} +: 4];

  // w_upper_zero[k] is set when digits k..7 of the displayed value are all zero
  assign w_upper_zero[7] = (r_active[31:28] == 4'd0);
  for (genvar k = 0; k < 7; k++) begin : g_zero_chain
    assign w_upper_zero[k] = w_upper_zero[k+1] && (r_active[4*k +: 4] == 4'd0);
  end

  // digit 0 is never blanked so an all-zero value still shows a single "0"
  assign w_blanked  = lz_en && (r_idx != 3'd0) && w_upper_zero[r_idx];
  assign w_anode_on = (r_pre >= PRE_GUARD) && (r_blink == '0) && !w_blanked;

  // one-hot active-low anode for the current slot, all off during guard/blink/blank
  always_comb begin
    w_anode_next = 8'hFF;
    if (w_anode_on) begin
      w_anode_next[r_idx] = 1'b0;
    end
  end

  // hex to active-low {g,f,e,d,c,b,a}
  always_comb begin
    w_hex = 7'h7F;
    case (w_digit)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  // slot prescaler and digit index; both restart from zero on reset
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= 3'd0;
    end else if (w_slot_end) begin
      r_pre <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // shadow captures on update; active only follows shadow at frame end so a frame is never torn
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_shadow <= 32'd0;
      r_active <= 32'd0;
    end else begin
      if (update) begin
        r_shadow <= digits_in;
      end
      if (w_frame_end) begin
        r_active <= r_shadow;
      end
    end
  end

  // blink frame counter: rollover (re)loads and beats the frame-end decrement
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_blink <= '0;
    end else if (rollover) begin
      r_blink <= BLINK_LOAD;
    end else if (w_frame_end && (r_blink != '0)) begin
      r_blink <= r_blink - BW'(1);
    end
  end

  // registered outputs
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_anode      <= 8'hFF;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_anode      <= w_anode_next;
      r_seg        <= {1'b1, w_hex};
      r_frame_done <= w_frame_end;
    end
  end

  assign anode      = r_anode;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule
